// File: rtl/multdiv_scheduler_if.sv
// Bus between the multdiv scheduler and the rest of the core: the operand and
// result handshake with the multdiv unit, plus the shared register-file write port.
interface multdiv_scheduler_if;
    // scheduler -> multdiv unit
    logic [31:0] md_in0;
    logic [31:0] md_in1;
    logic        md_start_mul;
    logic        md_start_div;
    logic        md_clear;
    logic        md_timeout;
    // multdiv unit -> scheduler
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    // register-file write port arbitration
    logic        wb_busy;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    modport master (
        output md_in0, md_in1, md_start_mul, md_start_div, md_clear, md_timeout,
        output wb_we, wb_reg, wb_data,
        input  md_result, md_exception, md_resultRDY, wb_busy
    );

    modport slave (
        input  md_in0, md_in1, md_start_mul, md_start_div, md_clear, md_timeout,
        input  wb_we, wb_reg, wb_data,
        output md_result, md_exception, md_resultRDY, wb_busy
    );
endinterface

// File: rtl/multdiv_scheduler.sv
// Multdiv scheduler: issues one mult/div at a time to a multi-cycle unit, holds
// operands stable while it runs, buffers the result, and writes it back through
// the shared register-file port when the main pipeline leaves it free. Also
// raises DX stalls for structural and RAW hazards against the pending result.
module multdiv_scheduler #(
    parameter int TIMEOUT     = 63,
    parameter int RSTATUS_REG = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        isMul,
    input  logic        isDiv,
    input  logic [4:0]  rd_dx,
    input  logic [4:0]  rs_dx,
    input  logic [4:0]  rt_dx,
    input  logic        dx_writes,
    input  logic [31:0] rd_out0_dx,
    input  logic [31:0] rd_out1_dx,
    output logic        stall_dx,
    output logic        busy,
    multdiv_scheduler_if.master bus
);

    localparam logic [5:0] TIMEOUT_CNT = 6'(TIMEOUT);
    localparam logic [4:0] RSTATUS_IDX = 5'(RSTATUS_REG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Exception code written to rstatus: 4 for a faulting mult, 5 for a div.
    function automatic logic [31:0] exc_code(input logic op_div);
        return op_div ? 32'd5 : 32'd4;
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] in0_q, in0_d;
    logic [31:0] in1_q, in1_d;
    logic [4:0]  rd_pend_q, rd_pend_d;
    logic        is_mult_q, is_mult_d;
    logic        is_div_q, is_div_d;
    logic [31:0] res_q, res_d;
    logic        exc_q, exc_d;

    logic issue_req;
    logic rdy_evt;
    logic to_evt;
    logic wr_needed;
    logic hazard;
    logic wb_fire;

    // Event decode shared by next-state and output logic
    always_comb begin
        issue_req = isMul | isDiv;
        rdy_evt   = (state_q == BUSY) && bus.md_resultRDY;
        // A result arriving on the last allowed cycle still wins over the abort.
        to_evt    = (state_q == BUSY) && !bus.md_resultRDY && (cnt_q == TIMEOUT_CNT);
        // Writes to r0 are dropped unless an exception redirects them to rstatus.
        wr_needed = exc_q || (rd_pend_q != 5'd0);
        hazard    = (rd_pend_q != 5'd0) &&
                    ((rs_dx == rd_pend_q) || (rt_dx == rd_pend_q) ||
                     (dx_writes && (rd_dx == rd_pend_q)));
        wb_fire   = !reset && (state_q == HOLD) && !bus.wb_busy && wr_needed;
    end

    // Next-state and datapath latch logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in0_d     = in0_q;
        in1_d     = in1_q;
        rd_pend_d = rd_pend_q;
        is_mult_d = is_mult_q;
        is_div_d  = is_div_q;
        res_d     = res_q;
        exc_d     = exc_q;
        case (state_q)
            IDLE: begin
                if (issue_req) begin
                    state_d   = BUSY;
                    cnt_d     = 6'd0;
                    in0_d     = rd_out0_dx;
                    in1_d     = rd_out1_dx;
                    rd_pend_d = rd_dx;
                    // Both opcode bits high is illegal; resolve it as a mult.
                    is_mult_d = isMul;
                    is_div_d  = isDiv & ~isMul;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 6'd1;
                if (rdy_evt) begin
                    res_d   = bus.md_result;
                    exc_d   = bus.md_exception;
                    state_d = HOLD;
                end else if (to_evt) begin
                    res_d   = 32'd0;
                    exc_d   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Leave once the write port is free, even if the write was suppressed.
                if (!bus.wb_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and buffer registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            in0_q     <= 32'd0;
            in1_q     <= 32'd0;
            rd_pend_q <= 5'd0;
            is_mult_q <= 1'b0;
            is_div_q  <= 1'b0;
            res_q     <= 32'd0;
            exc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            in0_q     <= in0_d;
            in1_q     <= in1_d;
            rd_pend_q <= rd_pend_d;
            is_mult_q <= is_mult_d;
            is_div_q  <= is_div_d;
            res_q     <= res_d;
            exc_q     <= exc_d;
        end
    end

    // Outputs; everything that could launch work or a write is masked during reset
    always_comb begin
        busy             = (state_q != IDLE);
        bus.md_in0       = in0_q;
        bus.md_in1       = in1_q;
        // The counter is zero only on the first BUSY cycle, so it doubles as the start marker.
        bus.md_start_mul = !reset && (state_q == BUSY) && (cnt_q == 6'd0) && is_mult_q;
        bus.md_start_div = !reset && (state_q == BUSY) && (cnt_q == 6'd0) && is_div_q;
        bus.md_timeout   = !reset && to_evt;
        bus.md_clear     = reset || to_evt;
        bus.wb_we        = wb_fire;
        bus.wb_reg       = 5'd0;
        bus.wb_data      = 32'd0;
        if (wb_fire) begin
            if (exc_q) begin
                bus.wb_reg  = RSTATUS_IDX;
                bus.wb_data = exc_code(is_div_q);
            end else begin
                bus.wb_reg  = rd_pend_q;
                bus.wb_data = res_q;
            end
        end
        stall_dx = !reset && busy && (issue_req || hazard);
    end

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Directed bench for multdiv_scheduler: a table of complete mult/div transactions
// followed by hand-written hazard, timeout and reset sequences.
module tb_multdiv_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        isMul, isDiv, dx_writes;
    logic [4:0]  rd_dx, rs_dx, rt_dx;
    logic [31:0] rd_out0_dx, rd_out1_dx;
    logic        stall_dx, busy;

    multdiv_scheduler_if bus_if ();

    multdiv_scheduler #(.TIMEOUT(63), .RSTATUS_REG(30)) dut (
        .clock      (clock),
        .reset      (reset),
        .isMul      (isMul),
        .isDiv      (isDiv),
        .rd_dx      (rd_dx),
        .rs_dx      (rs_dx),
        .rt_dx      (rt_dx),
        .dx_writes  (dx_writes),
        .rd_out0_dx (rd_out0_dx),
        .rd_out1_dx (rd_out1_dx),
        .stall_dx   (stall_dx),
        .busy       (busy),
        .bus        (bus_if)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        mul;
        logic        div;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          wbb;
        logic        exp_smul;
        logic        exp_sdiv;
        logic        exp_we;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk5(input string nm, input logic [4:0] act, input logic [4:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic issue(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        isMul = m; isDiv = d; rd_out0_dx = a; rd_out1_dx = b; rd_dx = rd;
        #1;
        chk1("pre_issue_busy", busy, 1'b0);
        chk1("pre_issue_stall", stall_dx, 1'b0);
        step();
        isMul = 1'b0; isDiv = 1'b0;
        rd_out0_dx = 32'hDEAD_BEEF; rd_out1_dx = 32'h0BAD_F00D; rd_dx = 5'd0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        issue(v.mul, v.div, v.a, v.b, v.rd);
        #1;
        chk1("busy_after_issue", busy, 1'b1);
        chk1("start_mul", bus_if.md_start_mul, v.exp_smul);
        chk1("start_div", bus_if.md_start_div, v.exp_sdiv);
        chk32("md_in0", bus_if.md_in0, v.a);
        chk32("md_in1", bus_if.md_in1, v.b);
        for (int i = 0; i < v.lat; i++) begin
            step();
            #1;
            chk1("start_mul_once", bus_if.md_start_mul, 1'b0);
            chk1("start_div_once", bus_if.md_start_div, 1'b0);
            chk32("md_in0_stable", bus_if.md_in0, v.a);
            chk32("md_in1_stable", bus_if.md_in1, v.b);
        end
        bus_if.md_resultRDY = 1'b1;
        bus_if.md_result    = v.res;
        bus_if.md_exception = v.exc;
        bus_if.wb_busy      = (v.wbb > 0);
        step();
        bus_if.md_resultRDY = 1'b0;
        bus_if.md_result    = 32'h1234_5678;
        bus_if.md_exception = 1'b0;
        for (int i = 0; i < v.wbb; i++) begin
            #1;
            chk1("hold_we_low", bus_if.wb_we, 1'b0);
            chk32("hold_data_zero", bus_if.wb_data, 32'd0);
            chk1("hold_busy", busy, 1'b1);
            step();
        end
        bus_if.wb_busy = 1'b0;
        #1;
        chk1("wb_we", bus_if.wb_we, v.exp_we);
        chk5("wb_reg", bus_if.wb_reg, v.exp_reg);
        chk32("wb_data", bus_if.wb_data, v.exp_data);
        step();
        #1;
        chk1("idle_after_wb", busy, 1'b0);
        chk1("we_after_wb", bus_if.wb_we, 1'b0);
        if (idx < 0) $display("unused");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //                mul   div   a             b             rd     res      exc  lat wbb smul  sdiv  we    reg     data
        vecs[0] = '{1'b1, 1'b0, 32'd6,        32'd7,        5'd5,  32'd42,  1'b0, 3, 0, 1'b1, 1'b0, 1'b1, 5'd5,  32'd42};
        vecs[1] = '{1'b0, 1'b1, 32'd9,        32'd0,        5'd3,  32'd0,   1'b1, 2, 0, 1'b0, 1'b1, 1'b1, 5'd30, 32'd5};
        vecs[2] = '{1'b1, 1'b0, 32'd100,      32'd3,        5'd8,  32'd300, 1'b0, 1, 3, 1'b1, 1'b0, 1'b1, 5'd8,  32'd300};
        vecs[3] = '{1'b0, 1'b1, 32'd20,       32'd3,        5'd31, 32'd6,   1'b0, 5, 0, 1'b0, 1'b1, 1'b1, 5'd31, 32'd6};
        vecs[4] = '{1'b1, 1'b0, 32'd3,        32'd4,        5'd0,  32'd12,  1'b0, 2, 0, 1'b1, 1'b0, 1'b0, 5'd0,  32'd0};
        vecs[5] = '{1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd7, 32'd0,  1'b1, 4, 1, 1'b1, 1'b0, 1'b1, 5'd30, 32'd4};
        vecs[6] = '{1'b0, 1'b1, 32'd1,        32'd0,        5'd0,  32'd0,   1'b1, 0, 2, 1'b0, 1'b1, 1'b1, 5'd30, 32'd5};
        vecs[7] = '{1'b1, 1'b1, 32'd2,        32'd3,        5'd9,  32'd0,   1'b1, 2, 0, 1'b1, 1'b0, 1'b1, 5'd30, 32'd4};

        reset = 1'b1; isMul = 1'b0; isDiv = 1'b0; dx_writes = 1'b0;
        rd_dx = 5'd0; rs_dx = 5'd0; rt_dx = 5'd0;
        rd_out0_dx = 32'd0; rd_out1_dx = 32'd0;
        bus_if.md_result = 32'd0; bus_if.md_exception = 1'b0;
        bus_if.md_resultRDY = 1'b0; bus_if.wb_busy = 1'b0;

        // Power-on reset
        step();
        #1;
        chk1("rst_clear_high", bus_if.md_clear, 1'b1);
        step();
        reset = 1'b0;
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_md_in0", bus_if.md_in0, 32'd0);
        chk32("rst_md_in1", bus_if.md_in1, 32'd0);
        chk1("rst_start_mul", bus_if.md_start_mul, 1'b0);
        chk1("rst_we", bus_if.wb_we, 1'b0);
        chk5("rst_wb_reg", bus_if.wb_reg, 5'd0);
        chk32("rst_wb_data", bus_if.wb_data, 32'd0);
        chk1("rst_clear_low", bus_if.md_clear, 1'b0);

        // Table of full transactions
        for (int k = 0; k < 8; k++) begin
            run_vec(k, vecs[k]);
        end

        // RAW and structural hazards against pending rd=8
        issue(1'b1, 1'b0, 32'd1, 32'd2, 5'd8);
        rs_dx = 5'd8; #1; chk1("haz_rs", stall_dx, 1'b1);
        rs_dx = 5'd9; #1; chk1("haz_none", stall_dx, 1'b0);
        rt_dx = 5'd8; #1; chk1("haz_rt", stall_dx, 1'b1);
        rt_dx = 5'd0; dx_writes = 1'b1; rd_dx = 5'd8; #1; chk1("haz_waw", stall_dx, 1'b1);
        dx_writes = 1'b0; #1; chk1("haz_rd_nowrite", stall_dx, 1'b0);
        isDiv = 1'b1; #1; chk1("haz_struct", stall_dx, 1'b1);
        isDiv = 1'b0; rd_dx = 5'd0;
        step();
        step();
        bus_if.md_resultRDY = 1'b1; bus_if.md_result = 32'd77; bus_if.wb_busy = 1'b1;
        step();
        // Result-ready pulses while holding must not overwrite the buffer
        bus_if.md_result = 32'd999;
        rs_dx = 5'd8; #1; chk1("haz_hold", stall_dx, 1'b1);
        step();
        bus_if.md_resultRDY = 1'b0; bus_if.wb_busy = 1'b0; isDiv = 1'b1;
        #1;
        chk1("haz_wb_we", bus_if.wb_we, 1'b1);
        chk32("haz_wb_data", bus_if.wb_data, 32'd77);
        chk1("haz_stall_wb_cycle", stall_dx, 1'b1);
        step();
        #1;
        chk1("haz_idle_busy", busy, 1'b0);
        chk1("haz_idle_stall", stall_dx, 1'b0);
        isDiv = 1'b0; rs_dx = 5'd0;
        step();

        // Timeout: no result for 64 BUSY cycles (counter 0..63)
        issue(1'b1, 1'b0, 32'd5, 32'd6, 5'd4);
        for (int i = 0; i < 64; i++) begin
            #1;
            chk1("to_pulse", bus_if.md_timeout, (i == 63));
            if (i == 63) chk1("to_clear", bus_if.md_clear, 1'b1);
            if (i == 40) chk32("to_in0_stable", bus_if.md_in0, 32'd5);
            step();
        end
        #1;
        chk1("to_pulse_gone", bus_if.md_timeout, 1'b0);
        chk1("to_clear_gone", bus_if.md_clear, 1'b0);
        chk1("to_wb_we", bus_if.wb_we, 1'b1);
        chk5("to_wb_reg", bus_if.wb_reg, 5'd30);
        chk32("to_wb_data", bus_if.wb_data, 32'd4);
        step();
        #1;
        chk1("to_idle", busy, 1'b0);

        // Reset on BUSY cycle 10 discards the operation
        issue(1'b0, 1'b1, 32'd50, 32'd7, 5'd6);
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1; isMul = 1'b1; rs_dx = 5'd6;
        #1;
        chk1("mrst_clear", bus_if.md_clear, 1'b1);
        chk1("mrst_stall", stall_dx, 1'b0);
        chk1("mrst_start", bus_if.md_start_mul | bus_if.md_start_div, 1'b0);
        chk1("mrst_timeout", bus_if.md_timeout, 1'b0);
        chk1("mrst_we", bus_if.wb_we, 1'b0);
        step();
        reset = 1'b0; isMul = 1'b0;
        #1;
        chk1("mrst_idle", busy, 1'b0);
        chk32("mrst_in0", bus_if.md_in0, 32'd0);
        chk32("mrst_in1", bus_if.md_in1, 32'd0);
        chk1("mrst_stall_after", stall_dx, 1'b0);
        chk1("mrst_start_after", bus_if.md_start_mul | bus_if.md_start_div, 1'b0);
        // A late result from the aborted op must be ignored in IDLE
        bus_if.md_resultRDY = 1'b1; bus_if.md_result = 32'd7;
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            chk1("mrst_ignore_we", bus_if.wb_we, 1'b0);
            chk1("mrst_ignore_busy", busy, 1'b0);
        end
        bus_if.md_resultRDY = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
